// File: rtl/boot_pkg.sv
// boot_pkg: shared state encoding and protocol bytes for the UART boot sequencer.
package boot_pkg;

   typedef enum logic [2:0] {
      WAIT_MAGIC,
      LEN_LO,
      LEN_HI,
      PAYLOAD,
      CHECK,
      SEND_RESP,
      RUN
   } boot_state_t;

   localparam logic [7:0] BOOT_MAGIC = 8'hA5;
   localparam logic [7:0] BOOT_ACK   = 8'h06;
   localparam logic [7:0] BOOT_NAK   = 8'h15;

endpackage

// File: rtl/boot_word_assembler.sv
// boot_word_assembler: packs payload bytes LSB-first into 32-bit words and keeps the XOR checksum.
module boot_word_assembler (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        word_ready,
   output logic [7:0]  checksum
);

   logic [1:0]  idx;
   logic [23:0] sh;

   // The completed word is presented combinationally on the 4th byte so the top can register it next edge.
   assign word_ready = byte_valid && idx == 2'd3;
   assign word       = {byte_data, sh};

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         idx      <= '0;
         sh       <= '0;
         checksum <= '0;
      end else if (byte_valid) begin
         idx      <= idx + 2'd1;
         sh       <= {byte_data, sh[23:8]};
         checksum <= checksum ^ byte_data;
      end
   end

endmodule

// File: rtl/uart_boot_sequencer.sv
// uart_boot_sequencer: receives a framed program image over UART, writes it to instruction
// memory, verifies the XOR checksum, answers ACK/NAK and releases the core on success.
module uart_boot_sequencer
   import boot_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          MAX_WORDS   = 256,
   parameter int          TIMEOUT_CYC = 1_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   input  logic        skip_boot,
   input  logic        boot_req,
   output logic        cpu_run,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] words_loaded
);

   localparam logic [16:0] MAXW    = 17'(MAX_WORDS);
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

   boot_state_t state, state_nxt;
   logic [7:0]  len_lo, resp, checksum;
   logic [15:0] n, n_rx;
   logic [31:0] to_cnt, word;
   logic        word_ready, byte_valid, frame_start, timed, timeout, len_bad, last_word, chk_ok;

   assign n_rx        = {rx_data, len_lo};
   assign len_bad     = n_rx == 16'd0 || {1'b0, n_rx} > MAXW;
   assign frame_start = state == WAIT_MAGIC && !skip_boot && rx_valid && rx_data == BOOT_MAGIC;
   assign byte_valid  = state == PAYLOAD && rx_valid;
   assign last_word   = word_ready && words_loaded == n - 16'd1;
   assign chk_ok      = rx_data == checksum;
   assign timed       = state inside {LEN_LO, LEN_HI, PAYLOAD, CHECK};
   assign timeout     = timed && !rx_valid && to_cnt == TO_LAST;
   assign tx_data     = resp;

   boot_word_assembler u_asm (
      .clk        (clk),
      .reset      (reset),
      .clear      (frame_start),
      .byte_valid (byte_valid),
      .byte_data  (rx_data),
      .word       (word),
      .word_ready (word_ready),
      .checksum   (checksum)
   );

   always_ff @(posedge clk) begin
      if (!reset) state <= WAIT_MAGIC;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_MAGIC: state_nxt = skip_boot ? RUN : frame_start ? LEN_LO : WAIT_MAGIC;
         LEN_LO:     if (rx_valid) state_nxt = LEN_HI;
         LEN_HI:     if (rx_valid) state_nxt = len_bad ? SEND_RESP : PAYLOAD;
         PAYLOAD:    if (last_word) state_nxt = CHECK;
         CHECK:      if (rx_valid) state_nxt = SEND_RESP;
         SEND_RESP:  if (tx_ready) state_nxt = resp == BOOT_ACK ? RUN : WAIT_MAGIC;
         RUN:        if (boot_req) state_nxt = WAIT_MAGIC;
         default:    state_nxt = WAIT_MAGIC;
      endcase
      if (timeout) state_nxt = WAIT_MAGIC;
   end

   always_comb begin
      cpu_run  = state == RUN;
      tx_valid = state == SEND_RESP;
      busy     = state inside {LEN_LO, LEN_HI, PAYLOAD, CHECK, SEND_RESP};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
         words_loaded <= '0;
         done         <= 1'b0;
         err          <= 1'b0;
         len_lo       <= '0;
         n            <= '0;
         resp         <= '0;
         to_cnt       <= '0;
      end else begin
         imem_we <= word_ready;
         if (word_ready) begin
            imem_addr    <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
            imem_wdata   <= word;
            words_loaded <= words_loaded + 16'd1;
         end
         if (frame_start) begin
            err          <= 1'b0;
            done         <= 1'b0;
            words_loaded <= '0;
         end
         if (state == LEN_LO && rx_valid) len_lo <= rx_data;
         if (state == LEN_HI && rx_valid) begin
            n <= n_rx;
            if (len_bad) begin
               resp <= BOOT_NAK;
               err  <= 1'b1;
            end
         end
         if (state == CHECK && rx_valid) begin
            resp <= chk_ok ? BOOT_ACK : BOOT_NAK;
            if (!chk_ok) err <= 1'b1;
         end
         if (state == SEND_RESP && tx_ready && resp == BOOT_ACK) done <= 1'b1;
         if (timeout) err <= 1'b1;
         to_cnt <= (timed && !rx_valid) ? to_cnt + 32'd1 : '0;
      end
   end

endmodule
